// File: rtl/reg_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : reg_bus_arbiter_if
// Brief   : Two-master request/ack ports plus the shared register bus.
// Revision: 1.0
// ============================================================================
interface reg_bus_arbiter_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic                  i_m0_req;
   logic                  i_m0_we;
   logic [ADDR_WIDTH-1:0] i_m0_addr;
   logic [DATA_WIDTH-1:0] i_m0_wdata;
   logic                  o_m0_ack;
   logic [DATA_WIDTH-1:0] o_m0_rdata;

   logic                  i_m1_req;
   logic                  i_m1_we;
   logic [ADDR_WIDTH-1:0] i_m1_addr;
   logic [DATA_WIDTH-1:0] i_m1_wdata;
   logic                  o_m1_ack;
   logic [DATA_WIDTH-1:0] o_m1_rdata;

   logic [ADDR_WIDTH-1:0] o_addr_bus;
   logic [DATA_WIDTH-1:0] o_data_write_bus;
   logic                  o_wr_enable_bus;
   logic [DATA_WIDTH-1:0] i_data_read_bus;
   logic                  o_busy;

   modport slave (
      input  i_m0_req, i_m0_we, i_m0_addr, i_m0_wdata,
      output o_m0_ack, o_m0_rdata,
      input  i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata,
      output o_m1_ack, o_m1_rdata,
      output o_addr_bus, o_data_write_bus, o_wr_enable_bus, o_busy,
      input  i_data_read_bus
   );

   modport master (
      output i_m0_req, i_m0_we, i_m0_addr, i_m0_wdata,
      input  o_m0_ack, o_m0_rdata,
      output i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata,
      input  o_m1_ack, o_m1_rdata,
      input  o_addr_bus, o_data_write_bus, o_wr_enable_bus, o_busy,
      output i_data_read_bus
   );
endinterface
`default_nettype wire

// File: rtl/reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : reg_bus_arbiter
// Brief   : Round-robin two-master sequencer for the internal register bus.
// Revision: 1.0
// ============================================================================
module reg_bus_arbiter #(
   parameter int                  ADDR_WIDTH = 8,
   parameter int                  DATA_WIDTH = 8,
   parameter int                  RD_LATENCY = 1,
   parameter logic [ADDR_WIDTH-1:0] ADDR_IDLE = 8'hFF
) (
   input  wire logic              i_clk,
   input  wire logic              i_rst,
   reg_bus_arbiter_if.slave       bus
);
   localparam int CNT_W = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_XFER  = 2'd1,
      S_RWAIT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                r_state;
   logic                  r_grant;
   logic                  r_last_grant;
   logic                  r_we;
   logic [CNT_W-1:0]      r_cnt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_wr_en;
   logic                  r_busy;
   logic                  r_m0_ack;
   logic                  r_m1_ack;
   logic [DATA_WIDTH-1:0] r_m0_rdata;
   logic [DATA_WIDTH-1:0] r_m1_rdata;

   logic                  w_any_req;
   logic                  w_pick;
   logic                  w_pick_we;

   // On contention the master that was not served last wins.
   assign w_any_req = bus.i_m0_req | bus.i_m1_req;
   assign w_pick    = (bus.i_m0_req & bus.i_m1_req) ? ~r_last_grant : bus.i_m1_req;
   assign w_pick_we = w_pick ? bus.i_m1_we : bus.i_m0_we;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state      <= S_IDLE;
         r_grant      <= 1'b0;
         r_last_grant <= 1'b1;
         r_we         <= 1'b0;
         r_cnt        <= '0;
         r_addr       <= ADDR_IDLE;
         r_wdata      <= '0;
         r_wr_en      <= 1'b0;
         r_busy       <= 1'b0;
         r_m0_ack     <= 1'b0;
         r_m1_ack     <= 1'b0;
         r_m0_rdata   <= '0;
         r_m1_rdata   <= '0;
      end else begin
         r_m0_ack <= 1'b0;
         r_m1_ack <= 1'b0;
         r_wr_en  <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               r_addr <= ADDR_IDLE;
               if (w_any_req) begin
                  r_grant <= w_pick;
                  r_we    <= w_pick_we;
                  r_addr  <= w_pick ? bus.i_m1_addr : bus.i_m0_addr;
                  if (w_pick_we) begin
                     r_wdata <= w_pick ? bus.i_m1_wdata : bus.i_m0_wdata;
                  end
                  // Strobe is registered so it is high for the whole XFER cycle.
                  r_wr_en <= w_pick_we;
                  r_busy  <= 1'b1;
                  r_state <= S_XFER;
               end
            end
            S_XFER: begin
               if (r_we) begin
                  r_m0_ack <= ~r_grant;
                  r_m1_ack <= r_grant;
                  r_state  <= S_DONE;
               end else begin
                  r_cnt   <= CNT_W'(RD_LATENCY - 1);
                  r_state <= S_RWAIT;
               end
            end
            S_RWAIT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 2'd1;
               end else begin
                  if (r_grant) begin
                     r_m1_rdata <= bus.i_data_read_bus;
                  end else begin
                     r_m0_rdata <= bus.i_data_read_bus;
                  end
                  r_m0_ack <= ~r_grant;
                  r_m1_ack <= r_grant;
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               r_last_grant <= r_grant;
               r_addr       <= ADDR_IDLE;
               r_busy       <= 1'b0;
               r_state      <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_addr_bus       = r_addr;
   assign bus.o_data_write_bus = r_wdata;
   assign bus.o_wr_enable_bus  = r_wr_en;
   assign bus.o_busy           = r_busy;
   assign bus.o_m0_ack         = r_m0_ack;
   assign bus.o_m1_ack         = r_m1_ack;
   assign bus.o_m0_rdata       = r_m0_rdata;
   assign bus.o_m1_rdata       = r_m1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_bus_arbiter
// Brief   : Directed scoreboard bench for reg_bus_arbiter (latency 1 and 3).
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_reg_bus_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   reg_bus_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();
   reg_bus_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus3 ();

   reg_bus_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LATENCY(1), .ADDR_IDLE(8'hFF))
      u_dut  (.i_clk(clk), .i_rst(rst_n), .bus(bus.slave));
   reg_bus_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LATENCY(3), .ADDR_IDLE(8'hFF))
      u_dut3 (.i_clk(clk), .i_rst(rst_n), .bus(bus3.slave));

   // Register file model: each address reads back addr ^ 0x3F (0x03 -> 0x3C).
   assign bus.i_data_read_bus  = bus.o_addr_bus ^ 8'h3F;
   assign bus3.i_data_read_bus = bus3.o_addr_bus ^ 8'h3F;

   typedef struct {
      logic       is_rd;
      logic [7:0] rdata;
      int         cyc;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   exp_t        q2[$];
   logic [15:0] qw[$];
   logic [7:0]  mrd [3];

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic check_ack(input int id, input logic ack, input logic [7:0] rd);
      exp_t e;
      logic have;
      have = 1'b0;
      if (ack) begin
         case (id)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
         endcase
         if (!have) begin
            check($sformatf("ack%0d_unexpected", id), 1, 0);
         end else begin
            check($sformatf("ack%0d_cycle", id), cyc, e.cyc);
            if (e.is_rd) mrd[id] = e.rdata;
         end
      end
      check($sformatf("rdata%0d", id), int'(rd), int'(mrd[id]));
   endtask

   // Monitor: pops expectations whenever the DUT presents an ack or write strobe.
   always @(negedge clk) begin
      logic [15:0] w;
      if (!rst_n) begin
         mrd[0] = 8'h00; mrd[1] = 8'h00; mrd[2] = 8'h00;
      end
      check_ack(0, bus.o_m0_ack, bus.o_m0_rdata);
      check_ack(1, bus.o_m1_ack, bus.o_m1_rdata);
      check_ack(2, bus3.o_m1_ack, bus3.o_m1_rdata);
      if (bus3.o_m0_ack) check("dut3_m0_ack_unexpected", 1, 0);
      if (bus3.o_wr_enable_bus) check("dut3_wr_unexpected", 1, 0);
      if (bus.o_wr_enable_bus) begin
         if (qw.size() == 0) begin
            check("wr_unexpected", 1, 0);
         end else begin
            w = qw.pop_front();
            check("wr_addr", int'(bus.o_addr_bus), int'(w[15:8]));
            check("wr_data", int'(bus.o_data_write_bus), int'(w[7:0]));
         end
      end
   end

   task automatic issue(input int id, input logic we, input logic [7:0] a,
                        input logic [7:0] d, input int ecyc);
      exp_t e;
      e.is_rd = ~we;
      e.rdata = a ^ 8'h3F;
      e.cyc   = ecyc;
      case (id)
         0: begin
            bus.i_m0_req = 1'b1; bus.i_m0_we = we; bus.i_m0_addr = a; bus.i_m0_wdata = d;
            q0.push_back(e);
         end
         1: begin
            bus.i_m1_req = 1'b1; bus.i_m1_we = we; bus.i_m1_addr = a; bus.i_m1_wdata = d;
            q1.push_back(e);
         end
         default: begin
            bus3.i_m1_req = 1'b1; bus3.i_m1_we = we; bus3.i_m1_addr = a; bus3.i_m1_wdata = d;
            q2.push_back(e);
         end
      endcase
      if (we && id != 2) qw.push_back({a, d});
   endtask

   task automatic drop(input int id);
      case (id)
         0:       bus.i_m0_req  = 1'b0;
         1:       bus.i_m1_req  = 1'b0;
         default: bus3.i_m1_req = 1'b0;
      endcase
   endtask

   function automatic logic ack_of(input int id);
      case (id)
         0:       return bus.o_m0_ack;
         1:       return bus.o_m1_ack;
         default: return bus3.o_m1_ack;
      endcase
   endfunction

   task automatic wait_ack(input int id);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         step();
         got = ack_of(id);
      end
      if (!got) check($sformatf("ack%0d_timeout", id), 0, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_addr"},   int'(bus.o_addr_bus), 'hFF);
      check({tag, "_wdata"},  int'(bus.o_data_write_bus), 0);
      check({tag, "_wr_en"},  int'(bus.o_wr_enable_bus), 0);
      check({tag, "_busy"},   int'(bus.o_busy), 0);
      check({tag, "_m0_ack"}, int'(bus.o_m0_ack), 0);
      check({tag, "_m1_ack"}, int'(bus.o_m1_ack), 0);
      check({tag, "_m0_rd"},  int'(bus.o_m0_rdata), 0);
      check({tag, "_m1_rd"},  int'(bus.o_m1_rdata), 0);
   endtask

   initial begin
      int c;
      bus.i_m0_req = 0; bus.i_m0_we = 0; bus.i_m0_addr = 0; bus.i_m0_wdata = 0;
      bus.i_m1_req = 0; bus.i_m1_we = 0; bus.i_m1_addr = 0; bus.i_m1_wdata = 0;
      bus3.i_m0_req = 0; bus3.i_m0_we = 0; bus3.i_m0_addr = 0; bus3.i_m0_wdata = 0;
      bus3.i_m1_req = 0; bus3.i_m1_we = 0; bus3.i_m1_addr = 0; bus3.i_m1_wdata = 0;
      repeat (3) step();
      check_reset_outputs("rst");
      rst_n = 1'b1;
      step();

      // Single m0 write: strobe in cycle 1, ack in cycle 2.
      issue(0, 1'b1, 8'h05, 8'hA5, cyc + 2);
      wait_ack(0);
      drop(0);
      step();

      // m1 read, latency 1 (ack cycle 3) and latency 3 (ack cycle 5).
      c = cyc;
      issue(1, 1'b0, 8'h03, 8'h00, c + 3);
      issue(2, 1'b0, 8'h03, 8'h00, c + 5);
      wait_ack(1);
      drop(1);
      wait_ack(2);
      drop(2);
      check("lat1_rdata", int'(bus.o_m1_rdata), 'h3C);
      check("lat3_rdata", int'(bus3.o_m1_rdata), 'h3C);
      step();

      // Both held for four transactions: m0,m1,m0,m1 every three cycles.
      c = cyc;
      issue(0, 1'b1, 8'h11, 8'h01, c + 2);
      issue(1, 1'b1, 8'h12, 8'h02, c + 5);
      wait_ack(0);
      issue(0, 1'b1, 8'h13, 8'h03, c + 8);
      wait_ack(1);
      issue(1, 1'b1, 8'h14, 8'h04, c + 11);
      wait_ack(0);
      drop(0);
      wait_ack(1);
      drop(1);
      step();

      // m0 read: req dropped and addr changed while in XFER.
      issue(0, 1'b0, 8'h07, 8'h00, cyc + 3);
      step();
      bus.i_m0_req  = 1'b0;
      bus.i_m0_addr = 8'h10;
      check("t4_addr_xfer", int'(bus.o_addr_bus), 'h07);
      step();
      check("t4_addr_rwait", int'(bus.o_addr_bus), 'h07);
      wait_ack(0);
      repeat (5) step();
      check("t4_no_second_busy", int'(bus.o_busy), 0);
      check("t4_q0_empty", q0.size(), 0);

      // Reset during RWAIT of an m1 read.
      c = cyc;
      issue(1, 1'b0, 8'h03, 8'h00, c + 3);
      step();
      step();
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      q1.delete();
      bus.i_m0_req = 1'b1; bus.i_m0_we = 1'b1; bus.i_m0_addr = 8'h20; bus.i_m0_wdata = 8'h11;
      repeat (2) step();
      rst_n = 1'b1;
      c = cyc;
      issue(0, 1'b1, 8'h20, 8'h11, c + 2);
      issue(1, 1'b0, 8'h03, 8'h00, c + 6);
      wait_ack(0);
      drop(0);
      wait_ack(1);
      drop(1);
      step();

      // Quiet bus for 20 cycles.
      repeat (20) begin
         step();
         check("idle_addr", int'(bus.o_addr_bus), 'hFF);
         check("idle_wr_en", int'(bus.o_wr_enable_bus), 0);
         check("idle_busy", int'(bus.o_busy), 0);
      end

      repeat (3) step();
      check("left_q0", q0.size(), 0);
      check("left_q1", q1.size(), 0);
      check("left_q2", q2.size(), 0);
      check("left_qw", qw.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
